// File: rtl/pipe_front_regs.sv
// pipe_front_regs: PC, IF/ID and ID/EX pipeline registers for a 5-stage RISC-V core.
// Latency: Instr at PC_F in cycle n -> Instr_D in n+1 -> Ctrl_E in n+2 (no stalls).
// Backpressure: Stall_F/Stall_D hold PC and IF/ID; flushes squash D/E to bubbles; redirect beats stall.
//
// Ports:
//   clk, rst                  - rising-edge clock, async active-high reset
//   Stall_F/Stall_D/Flush_D/Flush_E - hazard unit controls
//   PCSrc_E, PCTarget_E       - fetch redirect
//   Instr_F                   - instruction memory data for PC_F
//   Ctrl_D, RD1_D, RD2_D, ImmExt_D - decode-stage control and data
//   PC_F                      - fetch address
//   Instr_D, PC_D, PCPlus4_D, Valid_D, Rs1_D, Rs2_D, Rd_D - IF/ID state
//   Ctrl_E, RD1_E, RD2_E, ImmExt_E, PC_E, PCPlus4_E, Rs1_E, Rs2_E, Rd_E, Valid_E - ID/EX state
//   StallCnt, FlushCnt        - performance counters
// Build option: define PIPE_PERF_CNT_EN to implement the counters; otherwise they read 0.
module pipe_front_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CTRL_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Stall_F,
    input  logic              Stall_D,
    input  logic              Flush_D,
    input  logic              Flush_E,
    input  logic              PCSrc_E,
    input  logic [31:0]       PCTarget_E,
    input  logic [31:0]       Instr_F,
    input  logic [CTRL_W-1:0] Ctrl_D,
    input  logic [31:0]       RD1_D,
    input  logic [31:0]       RD2_D,
    input  logic [31:0]       ImmExt_D,
    output logic [31:0]       PC_F,
    output logic [31:0]       Instr_D,
    output logic [31:0]       PC_D,
    output logic [31:0]       PCPlus4_D,
    output logic              Valid_D,
    output logic [4:0]        Rs1_D,
    output logic [4:0]        Rs2_D,
    output logic [4:0]        Rd_D,
    output logic [CTRL_W-1:0] Ctrl_E,
    output logic [31:0]       RD1_E,
    output logic [31:0]       RD2_E,
    output logic [31:0]       ImmExt_E,
    output logic [31:0]       PC_E,
    output logic [31:0]       PCPlus4_E,
    output logic [4:0]        Rs1_E,
    output logic [4:0]        Rs2_E,
    output logic [4:0]        Rd_E,
    output logic              Valid_E,
    output logic [31:0]       StallCnt,
    output logic [31:0]       FlushCnt
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [31:0]       r_pc_f;
    logic [31:0]       w_pcplus4_f;
    logic [31:0]       r_instr_d, r_pc_d, r_pcplus4_d;
    logic              r_valid_d;
    logic [CTRL_W-1:0] r_ctrl_e;
    logic [31:0]       r_rd1_e, r_rd2_e, r_imm_e, r_pc_e, r_pcplus4_e;
    logic [4:0]        r_rs1_e, r_rs2_e, r_rd_e;
    logic              r_valid_e;

    assign w_pcplus4_f = r_pc_f + 32'd4;   // wraps silently at 2^32

    // PC: a redirect must land even while fetch is stalled, otherwise the
    // squashed wrong-path fetch would be retried after the stall clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_f <= RESET_PC;
        end else if (PCSrc_E) begin
            r_pc_f <= PCTarget_E;
        end else if (!Stall_F) begin
            r_pc_f <= w_pcplus4_f;
        end
    end

    // IF/ID: flush beats stall so a squashed slot never survives a hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_d   <= NOP_INSTR;
            r_pc_d      <= '0;
            r_pcplus4_d <= '0;
            r_valid_d   <= 1'b0;
        end else if (Flush_D) begin
            r_instr_d   <= NOP_INSTR;
            r_pc_d      <= '0;
            r_pcplus4_d <= '0;
            r_valid_d   <= 1'b0;
        end else if (!Stall_D) begin
            r_instr_d   <= Instr_F;
            r_pc_d      <= r_pc_f;
            r_pcplus4_d <= w_pcplus4_f;
            r_valid_d   <= 1'b1;
        end
    end

    assign Rs1_D = r_instr_d[19:15];
    assign Rs2_D = r_instr_d[24:20];
    assign Rd_D  = r_instr_d[11:7];

    // ID/EX: no hold path; a load-use stall shows up here as a flush bubble.
    // Control is zeroed for an invalid D slot so it cannot write state later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl_e    <= '0;
            r_rd1_e     <= '0;
            r_rd2_e     <= '0;
            r_imm_e     <= '0;
            r_pc_e      <= '0;
            r_pcplus4_e <= '0;
            r_rs1_e     <= '0;
            r_rs2_e     <= '0;
            r_rd_e      <= '0;
            r_valid_e   <= 1'b0;
        end else if (Flush_E) begin
            r_ctrl_e    <= '0;
            r_rd1_e     <= '0;
            r_rd2_e     <= '0;
            r_imm_e     <= '0;
            r_pc_e      <= '0;
            r_pcplus4_e <= '0;
            r_rs1_e     <= '0;
            r_rs2_e     <= '0;
            r_rd_e      <= '0;
            r_valid_e   <= 1'b0;
        end else begin
            r_ctrl_e    <= r_valid_d ? Ctrl_D : '0;
            r_rd1_e     <= RD1_D;
            r_rd2_e     <= RD2_D;
            r_imm_e     <= ImmExt_D;
            r_pc_e      <= r_pc_d;
            r_pcplus4_e <= r_pcplus4_d;
            r_rs1_e     <= Rs1_D;
            r_rs2_e     <= Rs2_D;
            r_rd_e      <= Rd_D;
            r_valid_e   <= r_valid_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stall_cnt, r_flush_cnt;

    // A stall cycle that is also flushed is counted as a flush only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (Stall_D && !Flush_D) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (PCSrc_E)             r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

    assign PC_F      = r_pc_f;
    assign Instr_D   = r_instr_d;
    assign PC_D      = r_pc_d;
    assign PCPlus4_D = r_pcplus4_d;
    assign Valid_D   = r_valid_d;
    assign Ctrl_E    = r_ctrl_e;
    assign RD1_E     = r_rd1_e;
    assign RD2_E     = r_rd2_e;
    assign ImmExt_E  = r_imm_e;
    assign PC_E      = r_pc_e;
    assign PCPlus4_E = r_pcplus4_e;
    assign Rs1_E     = r_rs1_e;
    assign Rs2_E     = r_rs2_e;
    assign Rd_E      = r_rd_e;
    assign Valid_E   = r_valid_e;

endmodule

// File: tb/tb_pipe_front_regs.sv
// tb_pipe_front_regs: directed checks of PC, IF/ID and ID/EX behaviour.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: stall/flush/redirect patterns driven directly as vectors.
module tb_pipe_front_regs;

    localparam int CTRL_W = 12;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk, rst;
    logic              Stall_F, Stall_D, Flush_D, Flush_E, PCSrc_E;
    logic [31:0]       PCTarget_E, Instr_F, RD1_D, RD2_D, ImmExt_D;
    logic [CTRL_W-1:0] Ctrl_D;
    logic [31:0]       PC_F, Instr_D, PC_D, PCPlus4_D;
    logic              Valid_D, Valid_E;
    logic [4:0]        Rs1_D, Rs2_D, Rd_D, Rs1_E, Rs2_E, Rd_E;
    logic [CTRL_W-1:0] Ctrl_E;
    logic [31:0]       RD1_E, RD2_E, ImmExt_E, PC_E, PCPlus4_E, StallCnt, FlushCnt;

    int n_chk = 0;
    int n_err = 0;

    pipe_front_regs #(.RESET_PC(32'h0000_0100), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D), .Flush_E(Flush_E),
        .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E), .Instr_F(Instr_F),
        .Ctrl_D(Ctrl_D), .RD1_D(RD1_D), .RD2_D(RD2_D), .ImmExt_D(ImmExt_D),
        .PC_F(PC_F), .Instr_D(Instr_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D), .Valid_D(Valid_D),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
        .Ctrl_E(Ctrl_E), .RD1_E(RD1_E), .RD2_E(RD2_E), .ImmExt_E(ImmExt_E),
        .PC_E(PC_E), .PCPlus4_E(PCPlus4_E), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
        .Valid_E(Valid_E), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model.
    function automatic logic [31:0] imem(input logic [31:0] pc);
        case (pc)
            32'h0000_0100: imem = 32'h0050_0093;  // addi x1,x0,5
            32'h0000_0104: imem = 32'h00A0_0113;  // addi x2,x0,10
            32'h0000_0108: imem = 32'h0030_0193;  // addi x3,x0,3
            default:       imem = 32'h0000_0013;
        endcase
    endfunction

    // Decode-side stimulus derived from Instr_D; top bit inverted so a NOP
    // still presents nonzero control (exercises the invalid-slot zeroing).
    assign Instr_F  = imem(PC_F);
    assign Ctrl_D   = {~Instr_D[31], Instr_D[30:20]};
    assign RD1_D    = Instr_D ^ 32'hFFFF_0000;
    assign RD2_D    = Instr_D + 32'h0000_1000;
    assign ImmExt_D = {20'h0, Instr_D[31:20]};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sf, input logic sd, input logic fd, input logic fe,
                         input logic ps, input logic [31:0] tgt);
        Stall_F = sf; Stall_D = sd; Flush_D = fd; Flush_E = fe; PCSrc_E = ps; PCTarget_E = tgt;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 32'h0);
        step(); step();
        chk("rst_pc",      PC_F,    32'h100);
        chk("rst_instr_d", Instr_D, 32'h13);
        chk("rst_valid_d", {31'h0, Valid_D}, 32'h0);
        chk("rst_valid_e", {31'h0, Valid_E}, 32'h0);
        chk("rst_ctrl_e",  {20'h0, Ctrl_E}, 32'h0);
        chk("rst_pc_d",    PC_D,    32'h0);
        rst = 1'b0;

        // Edge 1: first fetch enters D.
        step();
        chk("e1_pc",      PC_F,    32'h104);
        chk("e1_instr_d", Instr_D, 32'h0050_0093);
        chk("e1_valid_d", {31'h0, Valid_D}, 32'h1);
        chk("e1_valid_e", {31'h0, Valid_E}, 32'h0);
        chk("e1_rd_d",    {27'h0, Rd_D}, 32'h1);
        chk("e1_pc4_d",   PCPlus4_D, 32'h104);

        // Edge 2: first instruction reaches E.
        step();
        chk("e2_pc",      PC_F,    32'h108);
        chk("e2_instr_d", Instr_D, 32'h00A0_0113);
        chk("e2_valid_e", {31'h0, Valid_E}, 32'h1);
        chk("e2_rd_e",    {27'h0, Rd_E}, 32'h1);
        chk("e2_ctrl_e",  {20'h0, Ctrl_E}, 32'h805);
        chk("e2_pc_e",    PC_E,    32'h100);
        chk("e2_pc4_e",   PCPlus4_E, 32'h104);
        chk("e2_imm_e",   ImmExt_E, 32'h5);
        chk("e2_rd1_e",   RD1_E,   32'hFFAF_0093);
        chk("e2_rs2_e",   {27'h0, Rs2_E}, 32'h5);

        // Edge 3: load-use stall.
        drive(1, 1, 0, 1, 0, 32'h0);
        step();
        chk("lu_pc",      PC_F,    32'h108);
        chk("lu_instr_d", Instr_D, 32'h00A0_0113);
        chk("lu_valid_e", {31'h0, Valid_E}, 32'h0);
        chk("lu_ctrl_e",  {20'h0, Ctrl_E}, 32'h0);
        chk("lu_rd_e",    {27'h0, Rd_E}, 32'h0);
        chk("lu_stallcnt", StallCnt, PERF ? 32'h1 : 32'h0);

        // Edge 4: dependent instruction enters E one cycle late.
        drive(0, 0, 0, 0, 0, 32'h0);
        step();
        chk("e4_pc",      PC_F,    32'h10C);
        chk("e4_instr_d", Instr_D, 32'h0030_0193);
        chk("e4_rd_e",    {27'h0, Rd_E}, 32'h2);
        chk("e4_ctrl_e",  {20'h0, Ctrl_E}, 32'h80A);
        chk("e4_valid_e", {31'h0, Valid_E}, 32'h1);

        // Edge 5: taken branch.
        drive(0, 0, 1, 1, 1, 32'h200);
        step();
        chk("br_pc",      PC_F,    32'h200);
        chk("br_instr_d", Instr_D, 32'h13);
        chk("br_valid_d", {31'h0, Valid_D}, 32'h0);
        chk("br_valid_e", {31'h0, Valid_E}, 32'h0);
        chk("br_rd_d",    {27'h0, Rd_D}, 32'h0);
        chk("br_flushcnt", FlushCnt, PERF ? 32'h1 : 32'h0);

        // Edge 6: refill from target.
        drive(0, 0, 0, 0, 0, 32'h0);
        step();
        chk("e6_pc",      PC_F,    32'h204);
        chk("e6_pc_d",    PC_D,    32'h200);
        chk("e6_valid_d", {31'h0, Valid_D}, 32'h1);
        chk("e6_ctrl_e",  {20'h0, Ctrl_E}, 32'h0);

        // Edge 7: stall, flush and redirect together.
        drive(1, 1, 1, 0, 1, 32'h40);
        step();
        chk("sf_pc",      PC_F,    32'h40);
        chk("sf_valid_d", {31'h0, Valid_D}, 32'h0);
        chk("sf_instr_d", Instr_D, 32'h13);
        chk("sf_pc_e",    PC_E,    32'h200);
        chk("sf_valid_e", {31'h0, Valid_E}, 32'h1);
        chk("sf_stallcnt", StallCnt, PERF ? 32'h1 : 32'h0);
        chk("sf_flushcnt", FlushCnt, PERF ? 32'h2 : 32'h0);

        // Edge 8: invalid D slot with nonzero Ctrl_D must give Ctrl_E=0.
        drive(0, 0, 0, 0, 0, 32'h0);
        step();
        chk("inv_pc",      PC_F,   32'h44);
        chk("inv_ctrl_e",  {20'h0, Ctrl_E}, 32'h0);
        chk("inv_valid_e", {31'h0, Valid_E}, 32'h0);
        chk("inv_valid_d", {31'h0, Valid_D}, 32'h1);

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        chk("ar_pc",      PC_F,    32'h100);
        chk("ar_instr_d", Instr_D, 32'h13);
        chk("ar_valid_d", {31'h0, Valid_D}, 32'h0);
        chk("ar_pc_d",    PC_D,    32'h0);
        chk("ar_pc_e",    PC_E,    32'h0);
        chk("ar_stallcnt", StallCnt, 32'h0);
        chk("ar_flushcnt", FlushCnt, 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("rs_pc",      PC_F,    32'h104);
        chk("rs_instr_d", Instr_D, 32'h0050_0093);

        // PC wrap at 2^32.
        drive(0, 0, 1, 1, 1, 32'hFFFF_FFFC);
        step();
        chk("wr_pc0", PC_F, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 0, 32'h0);
        step();
        chk("wr_pc1", PC_F, 32'h0);
        chk("wr_pc4_d", PCPlus4_D, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
